uart_rx_engine: RTL

//   Parametrised UART receive engine: 16x-oversampled serial receiver with runtime

---
 rtl/uart_rx_engine_if.sv | 23 ++
 rtl/uart_rx_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine_if.sv
// Receive-side bus between uart_rx_engine and its consumer: FIFO head
// (data plus error flags), valid/ready pop handshake and occupancy.
interface uart_rx_engine_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_W-1:0]           rx_data;
  logic                        rx_parity_err;
  logic                        rx_frame_err;
  logic                        rx_valid;
  logic                        rx_ready;
  logic [$clog2(FIFO_DEPTH):0] rx_level;

  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_level,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_level,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x-oversampled UART receiver with runtime frame format
// (5-8 data bits, none/even/odd parity, 1/2 stop bits) feeding a show-ahead
// FIFO whose entries are {frame_err, parity_err, data}.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over the
// samples at sc = 7/8/9 instead of a single sample at sc = 8.
//
// state     | meaning
// S_IDLE    | line idle, hunting for a low level on a tick
// S_START   | validating the start bit, latching the frame format
// S_DATA    | shifting data bits in, LSB first
// S_PARITY  | checking the parity bit
// S_STOP    | sampling stop bit(s), pushing the word at the final sample
// S_WAIT_IDLE | framing error with line still low; wait for the line to go high
module uart_rx_engine #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  uart_rx_engine_if.master rx_bus,
  output logic             overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic             rxd_m, rxd_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       state;
  logic [3:0]       sc;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [1:0]       fmt_bits;
  logic             fmt_par, fmt_odd, fmt_stop2;
  logic             second_stop, par_err, frm_err;
  logic             push_q;
  logic [EW-1:0]    push_word;
  logic             sample_pt, bit_val, stop_err, last_bit;
  logic [7:0]       frame_data;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign tick = (div_cnt == baud_div);

  // Free-running 16x tick divider.
  always_ff @(posedge clock) begin
    if (reset) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

`ifdef UART_RX_MAJORITY_EN
  logic s7, s8;

  // Hold the early samples so the vote can be taken at sc = 9.
  always_ff @(posedge clock) begin
    if (reset) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (sc == 4'd7) s7 <= rxd_s;
      if (sc == 4'd8) s8 <= rxd_s;
    end
  end

  assign sample_pt = tick && (sc == 4'd9);
  assign bit_val   = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
`else
  assign sample_pt = tick && (sc == 4'd8);
  assign bit_val   = rxd_s;
`endif

  // Data enters at the MSB, so an N-bit frame is right-aligned by 8-N.
  assign frame_data = shreg >> (2'd3 - fmt_bits);
  assign last_bit   = (bit_idx == {1'b1, fmt_bits});
  assign stop_err   = frm_err | ~bit_val;

  // Frame sequencer; everything moves on the 16x tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      sc          <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      fmt_bits    <= '0;
      fmt_par     <= 1'b0;
      fmt_odd     <= 1'b0;
      fmt_stop2   <= 1'b0;
      second_stop <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      push_q      <= 1'b0;
      push_word   <= '0;
    end else begin
      push_q <= 1'b0;
      if (tick) begin
        sc <= sc + 4'd1;
        case (state)
          S_IDLE: begin
            sc <= '0;
            if (!rxd_s) state <= S_START;
          end
          S_START: begin
            if (sample_pt) begin
              if (bit_val) begin
                state <= S_IDLE;
              end else begin
                fmt_bits    <= data_bits;
                fmt_par     <= parity_en;
                fmt_odd     <= parity_odd;
                fmt_stop2   <= stop2;
                shreg       <= '0;
                bit_idx     <= '0;
                par_err     <= 1'b0;
                frm_err     <= 1'b0;
                second_stop <= 1'b0;
              end
            end else if (sc == 4'hf) begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (sample_pt) shreg <= {bit_val, shreg[7:1]};
            if (sc == 4'hf) begin
              bit_idx <= bit_idx + 3'd1;
              if (last_bit) state <= fmt_par ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            if (sample_pt) par_err <= ((^shreg) ^ bit_val) != fmt_odd;
            if (sc == 4'hf) state <= S_STOP;
          end
          S_STOP: begin
            if (sample_pt) begin
              if (fmt_stop2 && !second_stop) begin
                frm_err <= stop_err;
              end else begin
                push_q    <= 1'b1;
                push_word <= {stop_err, par_err, DATA_W'(frame_data)};
                state     <= (stop_err && !rxd_s) ? S_WAIT_IDLE : S_IDLE;
              end
            end else if (sc == 4'hf) begin
              second_stop <= 1'b1;
            end
          end
          S_WAIT_IDLE: begin
            if (rxd_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;
  logic [EW-1:0] head;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rx_bus.rx_valid & rx_bus.rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_q & (~full | pop);

  // FIFO storage, no reset needed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      overrun <= push_q & full & ~pop;
    end
  end

  assign head                 = mem[rd_ptr];
  assign rx_bus.rx_valid      = (count != '0);
  assign rx_bus.rx_level      = count;
  assign rx_bus.rx_data       = rx_bus.rx_valid ? head[DATA_W-1:0] : '0;
  assign rx_bus.rx_parity_err = rx_bus.rx_valid & head[DATA_W];
  assign rx_bus.rx_frame_err  = rx_bus.rx_valid & head[DATA_W+1];
endmodule
